// File: rtl/ddr4_pkg.sv
// Shared DDR4 write-path definitions.
//   - ddr4_clog2 : constant function used to size pointers, lane indices
//                  and occupancy counters.
//   - DDR4_NARROW_W / DDR4_RATIO / DDR4_WIDE_W : default user/DDR widths.
//   - DDR4_LANE_W : lane-index width for the default ratio.
package ddr4_pkg;

    localparam int DDR4_NARROW_W = 32;
    localparam int DDR4_RATIO    = 8;
    localparam int DDR4_WIDE_W   = DDR4_NARROW_W * DDR4_RATIO;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int ddr4_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    localparam int DDR4_LANE_W = ddr4_clog2(DDR4_RATIO);

endpackage

// File: rtl/ddr4_pack_fifo_if.sv
// Handshake bundle of the narrow-to-wide packing FIFO.
//   Write side : s_valid, s_ready, s_data, s_last
//   Read side  : m_valid, m_ready, m_data, m_keep, m_last, m_count, burst_rdy
//   master modport : the user/engine side driving beats and m_ready
//   slave modport  : the packing FIFO itself
interface ddr4_pack_fifo_if
    import ddr4_pkg::*;
#(
    parameter int NARROW_W = DDR4_NARROW_W,
    parameter int RATIO    = DDR4_RATIO,
    parameter int DEPTH    = 512
);
    localparam int WIDE_W = NARROW_W * RATIO;
    localparam int CNT_W  = ddr4_clog2(DEPTH) + 1;

    logic                s_valid;
    logic                s_ready;
    logic [NARROW_W-1:0] s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [WIDE_W-1:0]   m_data;
    logic [RATIO-1:0]    m_keep;
    logic                m_last;
    logic [CNT_W-1:0]    m_count;
    logic                burst_rdy;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last, m_count, burst_rdy
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last, m_count, burst_rdy
    );

endinterface

// File: rtl/ddr4_sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through output.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_data (ignored when full)
//   pop       : consume the presented head word (ignored when empty)
//   not_full  : registered, occupancy (including in-flight words) < DEPTH
//   rd_valid  : head word presented on rd_data
//   rd_data   : registered head word, zero while nothing is visible
//   count     : words visible on the read side
// A word written at edge N becomes visible after edge N+1.
module ddr4_sync_fifo
    import ddr4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic                         not_full,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic [ddr4_clog2(DEPTH):0]   count
);
    localparam int AW    = ddr4_clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [CNT_W-1:0] occ_r;
    logic [CNT_W-1:0] occ_next_s;
    logic [CNT_W-1:0] vis_r;
    logic [CNT_W-1:0] vis_next_s;
    logic             push_d_r;
    logic             not_full_r;
    logic             rd_valid_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             push_s;
    logic             pop_s;

    // Next-state pointer and counter arithmetic.
    always_comb begin
        push_s        = push && not_full_r;
        pop_s         = pop && (vis_r != {CNT_W{1'b0}});
        rd_ptr_next_s = rd_ptr_r + AW'(pop_s);
        occ_next_s    = occ_r + CNT_W'(push_s) - CNT_W'(pop_s);
        // vis lags occ by one cycle on the push side only.
        vis_next_s    = vis_r + CNT_W'(push_d_r) - CNT_W'(pop_s);
    end

    // Storage write port; contents are dead once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, counters and the registered head-word stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            occ_r      <= {CNT_W{1'b0}};
            vis_r      <= {CNT_W{1'b0}};
            push_d_r   <= 1'b0;
            not_full_r <= 1'b1;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_r + AW'(push_s);
            rd_ptr_r   <= rd_ptr_next_s;
            occ_r      <= occ_next_s;
            vis_r      <= vis_next_s;
            push_d_r   <= push_s;
            not_full_r <= (occ_next_s < CNT_W'(DEPTH));
            rd_valid_r <= (vis_next_s != {CNT_W{1'b0}});
            // A visible head was written at least one edge earlier, so the
            // memory already holds it; load zero when nothing is visible.
            rd_data_r  <= (vis_next_s != {CNT_W{1'b0}}) ? mem_r[rd_ptr_next_s]
                                                        : {WIDTH{1'b0}};
        end
    end

    assign not_full = not_full_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign count    = vis_r;

endmodule

// File: rtl/ddr4_pack_fifo.sv
// Narrow-to-wide packing FIFO for the DDR4 write path.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of ddr4_pack_fifo_if (user beats in, wide words
//              out with keep/last, visible count and burst-ready flag)
// Beats fill lanes LSB-first; a word commits on the last lane or on s_last.
// burst_rdy is set when BURST_LEN words are visible or any visible word
// carries m_last, so a short tail can be drained.
module ddr4_pack_fifo
    import ddr4_pkg::*;
#(
    parameter int NARROW_W  = DDR4_NARROW_W,
    parameter int RATIO     = DDR4_RATIO,
    parameter int DEPTH     = 512,
    parameter int BURST_LEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    ddr4_pack_fifo_if.slave  bus
);
    localparam int WIDE_W = NARROW_W * RATIO;
    localparam int LANE_W = ddr4_clog2(RATIO);
    localparam int CNT_W  = ddr4_clog2(DEPTH) + 1;
    localparam int WORD_W = WIDE_W + RATIO + 1;

    logic [LANE_W-1:0] lane_r;
    logic [WIDE_W-1:0] pack_data_r;
    logic [RATIO-1:0]  pack_keep_r;
    logic [WIDE_W-1:0] merged_data_s;
    logic [RATIO-1:0]  merged_keep_s;
    logic              accept_s;
    logic              commit_s;
    logic              pop_s;
    logic              not_full_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              commit_r;
    logic              commit_last_r;
    logic [CNT_W-1:0]  last_cnt_r;
    logic [CNT_W-1:0]  last_cnt_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              burst_rdy_r;

    assign bus.s_ready = !rst && not_full_s;

    // Merge the incoming beat into the current lane of the pack register.
    always_comb begin
        accept_s = bus.s_valid && bus.s_ready;
        commit_s = accept_s && ((lane_r == LANE_W'(RATIO - 1)) || bus.s_last);
        pop_s    = bus.m_valid && bus.m_ready;
        merged_data_s = pack_data_r;
        merged_keep_s = pack_keep_r;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_r == LANE_W'(i)) begin
                merged_data_s[i*NARROW_W +: NARROW_W] = bus.s_data;
                merged_keep_s[i]                      = 1'b1;
            end else begin
                merged_data_s[i*NARROW_W +: NARROW_W] = pack_data_r[i*NARROW_W +: NARROW_W];
                merged_keep_s[i]                      = pack_keep_r[i];
            end
        end
    end

    // Lane counter and pack register; cleared on commit so flushed words
    // carry zero data and keep in their unfilled lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r      <= {LANE_W{1'b0}};
            pack_data_r <= {WIDE_W{1'b0}};
            pack_keep_r <= {RATIO{1'b0}};
        end else if (accept_s) begin
            if (commit_s) begin
                lane_r      <= {LANE_W{1'b0}};
                pack_data_r <= {WIDE_W{1'b0}};
                pack_keep_r <= {RATIO{1'b0}};
            end else begin
                lane_r      <= lane_r + LANE_W'(1);
                pack_data_r <= merged_data_s;
                pack_keep_r <= merged_keep_s;
            end
        end
    end

    ddr4_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (commit_s),
        .wr_data  ({bus.s_last, merged_keep_s, merged_data_s}),
        .pop      (pop_s),
        .not_full (not_full_s),
        .rd_valid (bus.m_valid),
        .rd_data  (rd_word_s),
        .count    (bus.m_count)
    );

    assign bus.m_data = rd_word_s[WIDE_W-1:0];
    assign bus.m_keep = rd_word_s[WIDE_W +: RATIO];
    assign bus.m_last = rd_word_s[WORD_W-1];

    // Next visible count / last count; a commit becomes visible one edge
    // after it is pushed, mirroring the FIFO's visibility delay.
    always_comb begin
        count_next_s    = bus.m_count + CNT_W'(commit_r) - CNT_W'(pop_s);
        last_cnt_next_s = last_cnt_r + CNT_W'(commit_r && commit_last_r)
                                     - CNT_W'(pop_s && bus.m_last);
    end

    // Visible-last tracking and the registered burst-ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_r      <= 1'b0;
            commit_last_r <= 1'b0;
            last_cnt_r    <= {CNT_W{1'b0}};
            burst_rdy_r   <= 1'b0;
        end else begin
            commit_r      <= commit_s;
            commit_last_r <= bus.s_last;
            last_cnt_r    <= last_cnt_next_s;
            burst_rdy_r   <= (count_next_s >= CNT_W'(BURST_LEN))
                          || (last_cnt_next_s != {CNT_W{1'b0}});
        end
    end

    assign bus.burst_rdy = burst_rdy_r;

endmodule
